// File: rtl/hexseg_pkg.sv
// Shared constants for the animated 7-segment hex design.
package hexseg_pkg;
  localparam int CHAR_W             = 7;
  localparam int DEF_DEPTH          = 4;
  localparam int DEF_DEBOUNCE_TICKS = 3;

  typedef enum logic {
    DB_LOW  = 1'b0,
    DB_HIGH = 1'b1
  } db_state_e;
endpackage

// File: rtl/strobe_debouncer.sv
// Two-flop synchronizers plus a tick-sampled LOW/HIGH debouncer.
// press is a combinational one-cycle pulse on the qualifying tick that completes a rise.
module strobe_debouncer
  import hexseg_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              strobe_in,
  input  logic [CHAR_W-1:0] char_in,
  output logic [CHAR_W-1:0] char_s,
  output logic              press
);
  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_TICKS - 1);

  logic              r_strobe_m, r_strobe_s;
  logic [CHAR_W-1:0] r_char_m, r_char_s;
  db_state_e         r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              w_qual;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_strobe_m <= 1'b0;
      r_strobe_s <= 1'b0;
      r_char_m   <= '0;
      r_char_s   <= '0;
    end else begin
      r_strobe_m <= strobe_in;
      r_strobe_s <= r_strobe_m;
      r_char_m   <= char_in;
      r_char_s   <= r_char_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DB_LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A sample qualifies when it differs from the current debounced level.
  assign w_qual = (r_state == DB_LOW) ? r_strobe_s : ~r_strobe_s;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    press       = 1'b0;
    if (tick) begin
      if (!w_qual) begin
        w_cnt_nxt = '0;
      end else if (r_cnt == CNT_LAST) begin
        w_cnt_nxt   = '0;
        w_state_nxt = (r_state == DB_LOW) ? DB_HIGH : DB_LOW;
        press       = (r_state == DB_LOW);
      end else begin
        w_cnt_nxt = r_cnt + 4'd1;
      end
    end
  end

  assign char_s = r_char_s;
endmodule

// File: rtl/hex_char_queue.sv
// Captures a character on each debounced press into a circular FIFO read by the animator.
// Write lands the edge after press (no fall-through); a press into a full FIFO with no pop is dropped and sets sticky overflow.
module hex_char_queue
  import hexseg_pkg::*;
#(
  parameter int DEPTH          = DEF_DEPTH,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              strobe_in,
  input  logic [CHAR_W-1:0] char_in,
  input  logic              ready,
  input  logic              clear_ovf,
  output logic              char_valid,
  output logic [CHAR_W-1:0] char_out,
  output logic [3:0]        count,
  output logic              overflow
);
  localparam int         PTR_W    = $clog2(DEPTH);
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  logic              w_press;
  logic [CHAR_W-1:0] w_char_s;
  logic              w_full, w_pop, w_push, w_drop;
  logic [CHAR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd, r_wr;
  logic [3:0]        r_count;
  logic              r_overflow;

  strobe_debouncer #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .strobe_in(strobe_in),
    .char_in  (char_in),
    .char_s   (w_char_s),
    .press    (w_press)
  );

  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = char_valid & ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push = w_press & (~w_full | w_pop);
  assign w_drop = w_press & w_full & ~w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_W'(1);
      if (w_pop)  r_rd <= r_rd + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + 4'd1;
      else if (w_pop && !w_push) r_count <= r_count - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_char_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_overflow <= 1'b0;
    else if (w_drop)    r_overflow <= 1'b1;
    else if (clear_ovf) r_overflow <= 1'b0;
  end

  assign char_valid = (r_count != 4'd0);
  assign char_out   = char_valid ? r_mem[r_rd] : '0;
  assign count      = r_count;
  assign overflow   = r_overflow;
endmodule

// File: tb/tb_hex_char_queue.sv
// Bench for hex_char_queue: directed vectors and corner sequences plus random traffic against a queue model.
module tb_hex_char_queue;
  import hexseg_pkg::*;

  localparam int DEPTH = 4;
  localparam int DT    = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              tick = 1'b0;
  logic              strobe_in = 1'b0;
  logic [CHAR_W-1:0] char_in = '0;
  logic              ready = 1'b0;
  logic              clear_ovf = 1'b0;
  logic              char_valid;
  logic [CHAR_W-1:0] char_out;
  logic [3:0]        count;
  logic              overflow;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: sync pipeline, debounced level with run length, FIFO as a queue.
  logic       m_s1, m_s2, m_high, m_ovf;
  logic [6:0] m_c1, m_c2;
  int         m_run;
  logic [6:0] m_q[$];

  typedef struct {
    logic [6:0] ch;
    int         hi;
    int         exp_cnt;
    logic [6:0] exp_head;
  } vec_t;
  vec_t vt [5];

  always #5 clk = ~clk;

  hex_char_queue #(.DEPTH(DEPTH), .DEBOUNCE_TICKS(DT)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .strobe_in (strobe_in),
    .char_in   (char_in),
    .ready     (ready),
    .clear_ovf (clear_ovf),
    .char_valid(char_valid),
    .char_out  (char_out),
    .count     (count),
    .overflow  (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_c1 = '0; m_c2 = '0;
    m_high = 1'b0; m_run = 0; m_ovf = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step();
    logic qual, pr;
    qual = m_high ? !m_s2 : m_s2;
    pr   = tick && qual && !m_high && (m_run + 1 == DT);
    if (ready && m_q.size() > 0) void'(m_q.pop_front());
    if (pr && m_q.size() == DEPTH) m_ovf = 1'b1;
    else if (clear_ovf)            m_ovf = 1'b0;
    if (pr && m_q.size() < DEPTH)  m_q.push_back(m_c2);
    if (tick) begin
      if (qual) begin
        m_run++;
        if (m_run == DT) begin
          m_high = !m_high;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    m_s2 = m_s1; m_s1 = strobe_in;
    m_c2 = m_c1; m_c1 = char_in;
  endtask

  task automatic check_model();
    logic [6:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 7'h00;
    chk("model_count", 32'(count), 32'(m_q.size()));
    chk("model_valid", 32'(char_valid), 32'(m_q.size() != 0));
    chk("model_char", 32'(char_out), 32'(head));
    chk("model_ovf", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic cyc();
    if (reset) model_reset();
    else       model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  // Asynchronous assert mid-cycle; outputs must clear before any clock edge.
  task automatic apply_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(char_valid), 32'd0);
    chk("rst_char", 32'(char_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Press lands in iteration 4 (2 sync cycles + DT ticks), so ready/clear are aimed there.
  task automatic do_press(input logic [6:0] ch, input logic rdy_at, input logic clr_at);
    char_in = ch; strobe_in = 1'b1; tick = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ready     = rdy_at && (i == 4);
      clear_ovf = clr_at && (i == 4);
      cyc();
    end
    ready = 1'b0; clear_ovf = 1'b0; strobe_in = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
  endtask

  task automatic pop_expect(input logic [6:0] exp, input string nm);
    chk(nm, 32'(char_out), 32'(exp));
    ready = 1'b1;
    cyc();
    ready = 1'b0;
  endtask

  initial begin
    vt[0] = '{7'h0A, 5, 1, 7'h0A};
    vt[1] = '{7'h11, 2, 1, 7'h0A};
    vt[2] = '{7'h22, 3, 2, 7'h0A};
    vt[3] = '{7'h33, 1, 2, 7'h0A};
    vt[4] = '{7'h44, 4, 3, 7'h0A};

    apply_reset();

    // Single press latency: count rises after the 5th edge from the raw rise.
    char_in = 7'h0A; strobe_in = 1'b1; tick = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 3) chk("lat_before", 32'(count), 32'd0);
      if (i == 4) begin
        chk("lat_count", 32'(count), 32'd1);
        chk("lat_char", 32'(char_out), 32'h0A);
        chk("lat_valid", 32'(char_valid), 32'd1);
      end
    end
    chk("lat_once", 32'(count), 32'd1);
    strobe_in = 1'b0;
    for (int i = 0; i < 6; i++) cyc();

    // Table: pulses of varying qualifying-tick length.
    apply_reset();
    for (int v = 0; v < 5; v++) begin
      char_in = vt[v].ch; strobe_in = 1'b1; tick = 1'b0;
      cyc(); cyc();
      tick = 1'b1;
      for (int k = 0; k < vt[v].hi; k++) cyc();
      strobe_in = 1'b0; tick = 1'b0;
      cyc(); cyc();
      tick = 1'b1;
      for (int k = 0; k < 4; k++) cyc();
      chk($sformatf("vec%0d_count", v), 32'(count), 32'(vt[v].exp_cnt));
      chk($sformatf("vec%0d_head", v), 32'(char_out), 32'(vt[v].exp_head));
      chk($sformatf("vec%0d_ovf", v), 32'(overflow), 32'd0);
    end

    // Bounce then stable high.
    apply_reset();
    char_in = 7'h5A; tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      strobe_in = (i % 2 == 0);
      cyc();
    end
    chk("bounce_none", 32'(count), 32'd0);
    strobe_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 3) chk("bounce_early", 32'(count), 32'd0);
      if (i == 4) chk("bounce_push", 32'(count), 32'd1);
    end
    for (int i = 0; i < 3; i++) cyc();
    chk("bounce_once", 32'(count), 32'd1);
    chk("bounce_char", 32'(char_out), 32'h5A);
    strobe_in = 1'b0;
    for (int i = 0; i < 6; i++) cyc();

    // Fill past capacity, then drain.
    apply_reset();
    for (int c = 1; c <= 5; c++) do_press(7'(c), 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ovf", 32'(overflow), 32'd1);
    for (int c = 1; c <= 4; c++) pop_expect(7'(c), $sformatf("full_pop%0d", c));
    chk("full_empty", 32'(count), 32'd0);
    chk("full_empty_char", 32'(char_out), 32'd0);

    // Push and pop together while full.
    apply_reset();
    for (int c = 0; c < 4; c++) do_press(7'(8'h10 + c), 1'b0, 1'b0);
    do_press(7'h14, 1'b1, 1'b0);
    chk("pp_count", 32'(count), 32'd4);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_head", 32'(char_out), 32'h11);

    // Clear coinciding with an overflowing press loses to the set.
    do_press(7'h15, 1'b0, 1'b1);
    chk("clr_vs_set", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    cyc();
    clear_ovf = 1'b0;
    chk("clr_alone", 32'(overflow), 32'd0);
    for (int c = 1; c <= 4; c++) pop_expect(7'(8'h10 + c), $sformatf("pp_pop%0d", c));
    chk("pp_empty", 32'(count), 32'd0);

    // Reset with 3 queued and overflow set, strobe held high across release.
    apply_reset();
    for (int c = 0; c < 5; c++) do_press(7'(8'h20 + c), 1'b0, 1'b0);
    pop_expect(7'h20, "rq_pop");
    chk("rq_count", 32'(count), 32'd3);
    chk("rq_ovf", 32'(overflow), 32'd1);
    char_in = 7'h77; strobe_in = 1'b1; tick = 1'b1;
    cyc();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 3) chk("rq_no_spurious", 32'(count), 32'd0);
      if (i == 4) chk("rq_redebounce", 32'(count), 32'd1);
    end
    strobe_in = 1'b0;
    for (int i = 0; i < 6; i++) cyc();

    // Random traffic against the model.
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) apply_reset();
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) strobe_in = ~strobe_in;
      if (!strobe_in && $urandom_range(0, 3) == 0) char_in = 7'($urandom);
      ready     = ($urandom_range(0, 3) == 0);
      clear_ovf = ($urandom_range(0, 30) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
